// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_pkg : shared types and round-robin pick for div_scheduler        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package div_pkg;

  localparam int N_REQ_CFG = 4;
  localparam int ID_W      = $clog2(N_REQ_CFG);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            dbz;
  } tag_t;

  // One-hot grant for the lowest valid index at or after ptr, wrapping.
  function automatic logic [N_REQ_CFG-1:0] rr_pick(
    input logic [N_REQ_CFG-1:0] valid,
    input logic [ID_W-1:0]      ptr
  );
    logic [N_REQ_CFG-1:0] g;
    logic                 found;
    logic [ID_W-1:0]      idx;
    g     = '0;
    found = 1'b0;
    for (int off = 0; off < N_REQ_CFG; off++) begin
      idx = ID_W'((int'(ptr) + off) % N_REQ_CFG);
      if (!found && valid[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : round-robin pointer register and combinational grant     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter
  import div_pkg::*;
(
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [N_REQ_CFG-1:0] req_valid_i,
  output logic [N_REQ_CFG-1:0] grant_o,
  output logic [ID_W-1:0]      win_id_o,
  output logic                 xfer_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;

  always_comb begin
    grant_o  = rr_pick(req_valid_i, ptr_q);
    win_id_o = '0;
    for (int i = 0; i < N_REQ_CFG; i++) begin
      if (grant_o[i]) win_id_o = ID_W'(i);
    end
    xfer_o = |grant_o;
    ptr_d  = ptr_q;
    if (xfer_o) begin
      ptr_d = (win_id_o == ID_W'(N_REQ_CFG - 1)) ? '0 : win_id_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_scheduler : shares one pipelined divider among N_REQ requesters   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_scheduler
  import div_pkg::*;
#(
  parameter int N_REQ   = N_REQ_CFG,
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  parameter int LATENCY = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*A_WIDTH-1:0]   req_a,
  input  logic [N_REQ*B_WIDTH-1:0]   req_b,
  output logic [A_WIDTH-1:0]         div_a,
  output logic [B_WIDTH-1:0]         div_b,
  output logic                       div_valid,
  input  logic [A_WIDTH-1:0]         div_q,
  input  logic [B_WIDTH-2:0]         div_r,
  output logic [N_REQ-1:0]           resp_valid,
  output logic [A_WIDTH-1:0]         resp_q,
  output logic [B_WIDTH-1:0]         resp_r,
  output logic                       resp_dbz,
  output logic                       busy
);

  logic [N_REQ-1:0] grant_w;
  logic [ID_W-1:0]  win_id_w;
  logic             xfer_w;
  logic             dbz_w;

  rr_arbiter u_arb (
    .clk         (clk),
    .nreset      (nreset),
    .req_valid_i (req_valid),
    .grant_o     (grant_w),
    .win_id_o    (win_id_w),
    .xfer_o      (xfer_w)
  );

  assign req_ready = grant_w;
  assign div_valid = xfer_w;

  always_comb begin
    div_a = '0;
    div_b = '0;
    if (xfer_w) begin
      div_a = req_a[win_id_w*A_WIDTH +: A_WIDTH];
      div_b = req_b[win_id_w*B_WIDTH +: B_WIDTH];
    end
    dbz_w = xfer_w && (div_b == '0);
  end

  // Tag stage LATENCY-1 lines up with the divider result for that operation.
  tag_t tag_q [LATENCY];
  tag_t last_w;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < LATENCY; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag_t'{valid: xfer_w, id: win_id_w, dbz: dbz_w};
      for (int k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign last_w = tag_q[LATENCY-1];

  logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [A_WIDTH-1:0] resp_q_q,     resp_q_d;
  logic [B_WIDTH-1:0] resp_r_q,     resp_r_d;
  logic               resp_dbz_q,   resp_dbz_d;

  always_comb begin
    resp_valid_d = '0;
    resp_q_d     = resp_q_q;
    resp_r_d     = resp_r_q;
    resp_dbz_d   = resp_dbz_q;
    if (last_w.valid) begin
      resp_valid_d[last_w.id] = 1'b1;
      resp_dbz_d              = last_w.dbz;
      resp_q_d                = last_w.dbz ? '1 : div_q;
      resp_r_d                = last_w.dbz ? '0 : {1'b0, div_r};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      resp_valid_q <= '0;
      resp_q_q     <= '0;
      resp_r_q     <= '0;
      resp_dbz_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_q_q     <= resp_q_d;
      resp_r_q     <= resp_r_d;
      resp_dbz_q   <= resp_dbz_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_q     = resp_q_q;
  assign resp_r     = resp_r_q;
  assign resp_dbz   = resp_dbz_q;

  always_comb begin
    busy = |resp_valid_q;
    for (int k = 0; k < LATENCY; k++) busy = busy | tag_q[k].valid;
  end

endmodule
`default_nettype wire

// File: tb/tb_div_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_scheduler : scoreboard bench with a behavioural divider model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_div_scheduler;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int RW = BW - 1;
  localparam int L  = 4;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [AW-1:0]   div_a;
  logic [BW-1:0]   div_b;
  logic            div_valid;
  logic [AW-1:0]   div_q;
  logic [RW-1:0]   div_r;
  logic [N-1:0]    resp_valid;
  logic [AW-1:0]   resp_q;
  logic [BW-1:0]   resp_r;
  logic            resp_dbz;
  logic            busy;

  div_scheduler #(.N_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .LATENCY(L)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .div_a(div_a), .div_b(div_b), .div_valid(div_valid),
    .div_q(div_q), .div_r(div_r),
    .resp_valid(resp_valid), .resp_q(resp_q), .resp_r(resp_r),
    .resp_dbz(resp_dbz), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External pipelined divider, LATENCY cycles from issue to result.
  logic [AW-1:0] mq [L];
  logic [RW-1:0] mr [L];
  always @(posedge clk) begin
    mq[0] <= (div_b == '0) ? '1 : div_a / div_b;
    mr[0] <= (div_b == '0) ? '0 : RW'(div_a % div_b);
    for (int k = 1; k < L; k++) begin
      mq[k] <= mq[k-1];
      mr[k] <= mr[k-1];
    end
  end
  assign div_q = mq[L-1];
  assign div_r = mr[L-1];

  typedef struct {
    logic [N-1:0]  onehot;
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          dbz;
    int            due;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid !== '0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_resp: resp_valid=%b with nothing outstanding", resp_valid);
      end else begin
        e = sb.pop_front();
        if (resp_valid !== e.onehot) begin
          n_errors++;
          $display("FAIL resp_valid: got %b exp %b", resp_valid, e.onehot);
        end
        n_checks++;
        if (resp_q !== e.q) begin
          n_errors++;
          $display("FAIL resp_q: got %0d exp %0d", resp_q, e.q);
        end
        n_checks++;
        if (resp_r !== e.r) begin
          n_errors++;
          $display("FAIL resp_r: got %0d exp %0d", resp_r, e.r);
        end
        n_checks++;
        if (resp_dbz !== e.dbz) begin
          n_errors++;
          $display("FAIL resp_dbz: got %b exp %b", resp_dbz, e.dbz);
        end
        n_checks++;
        if (cyc !== e.due) begin
          n_errors++;
          $display("FAIL resp_timing: got cycle %0d exp cycle %0d", cyc, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  task automatic push_exp(input int i, input logic [AW-1:0] q, input logic [BW-1:0] r,
                          input logic dbz);
    exp_t e;
    e.onehot = '0;
    e.onehot[i] = 1'b1;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.due = cyc + L + 1;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    idle();
    nreset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++; if (req_ready !== '0) begin n_errors++; $display("FAIL rst_req_ready: got %b exp 0", req_ready); end
    n_checks++; if (div_valid !== 1'b0) begin n_errors++; $display("FAIL rst_div_valid: got %b exp 0", div_valid); end
    n_checks++; if (resp_valid !== '0) begin n_errors++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
    n_checks++; if (resp_q !== '0) begin n_errors++; $display("FAIL rst_resp_q: got %0d exp 0", resp_q); end
    n_checks++; if (resp_r !== '0) begin n_errors++; $display("FAIL rst_resp_r: got %0d exp 0", resp_r); end
    n_checks++; if (resp_dbz !== 1'b0) begin n_errors++; $display("FAIL rst_resp_dbz: got %b exp 0", resp_dbz); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
    tick();
    nreset = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL post_rst_busy: got %b exp 0", busy); end
    tick();
  endtask

  task automatic test_fairness();
    logic [AW-1:0] a [N];
    logic [BW-1:0] b [N];
    logic [N-1:0]  exp_g;
    int            w;
    for (int k = 0; k < 8; k++) begin
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
        a[i] = AW'(500 + 37 * i + 11 * k);
        b[i] = BW'(2 + i + (k % 3));
        set_op(i, a[i], b[i]);
      end
      @(negedge clk);
      w = k % N;
      exp_g = '0;
      exp_g[w] = 1'b1;
      n_checks++;
      if (req_ready !== exp_g) begin
        n_errors++;
        $display("FAIL fair_grant[%0d]: got %b exp %b", k, req_ready, exp_g);
      end
      n_checks++;
      if (div_a !== a[w] || div_b !== b[w] || div_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL fair_operands[%0d]: got %0d/%0d v=%b exp %0d/%0d v=1",
                 k, div_a, div_b, div_valid, a[w], b[w]);
      end
      push_exp(w, a[w] / b[w], a[w] % b[w], 1'b0);
      tick();
    end
    idle();
    wait_drain("fair");
  endtask

  task automatic test_single();
    idle();
    req_valid = 4'b0001;
    set_op(0, 16'd622, 16'd3);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_grant: got %b exp 0001", req_ready); end
    n_checks++;
    if (div_a !== 16'd622 || div_b !== 16'd3 || div_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL single_issue: got %0d/%0d v=%b exp 622/3 v=1", div_a, div_b, div_valid);
    end
    push_exp(0, 16'd207, 16'd1, 1'b0);
    tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %b exp 1", busy); end
    wait_drain("single");
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL single_idle_busy: got %b exp 0", busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    req_valid = 4'b0010;
    set_op(1, 16'd1000, 16'd7);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL b2b_grant0: got %b exp 0010", req_ready); end
    push_exp(1, 16'd142, 16'd6, 1'b0);
    tick();
    set_op(1, 16'd1000, 16'd9);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL b2b_grant1: got %b exp 0010", req_ready); end
    push_exp(1, 16'd111, 16'd1, 1'b0);
    tick();
    idle();
    wait_drain("b2b");
  endtask

  task automatic test_dbz();
    idle();
    req_valid = 4'b0100;
    set_op(2, 16'd100, 16'd0);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100 || div_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL dbz_issue: got ready=%b v=%b exp ready=0100 v=1", req_ready, div_valid);
    end
    push_exp(2, 16'hFFFF, 16'd0, 1'b1);
    tick();
    idle();
    wait_drain("dbz");
  endtask

  task automatic test_sparse_wrap();
    idle();
    req_valid = 4'b0010;
    set_op(1, 16'd40, 16'd6);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL sparse_grant: got %b exp 0010", req_ready); end
    push_exp(1, 16'd6, 16'd4, 1'b0);
    tick();
    req_valid = 4'b1010;
    set_op(3, 16'd81, 16'd9);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL wrap_grant3: got %b exp 1000", req_ready); end
    push_exp(3, 16'd9, 16'd0, 1'b0);
    tick();
    req_valid = 4'b1111;
    set_op(0, 16'd7, 16'd2);
    set_op(2, 16'd9, 16'd4);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL wrap_grant0: got %b exp 0001", req_ready); end
    push_exp(0, 16'd3, 16'd1, 1'b0);
    tick();
    idle();
    wait_drain("wrap");
  endtask

  task automatic test_reset_midflight();
    idle();
    req_valid = 4'b0111;
    for (int i = 0; i < N; i++) set_op(i, AW'(300 + i), BW'(5 + i));
    repeat (3) tick();
    idle();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL midrst_busy_before: got %b exp 1", busy); end
    tick();
    nreset = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_async_clear: got busy=%b exp 0", busy); end
    tick();
    nreset = 1'b1;
    repeat (2 * L + 4) tick();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy_after: got %b exp 0", busy); end
    tick();
    req_valid = 4'b1111;
    set_op(0, 16'd55, 16'd5);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL midrst_next_grant: got %b exp 0001", req_ready); end
    push_exp(0, 16'd11, 16'd0, 1'b0);
    tick();
    idle();
    wait_drain("midrst");
  endtask

  initial begin
    idle();
    test_reset();
    test_fairness();
    test_single();
    test_back_to_back();
    test_dbz();
    test_sparse_wrap();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
